muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative sequencer for the 6-bit multiply/divide datapath. Accepts one operation per start pulse and steps a shift-add multiply or a restoring divide, one bit per clock, through the shared HA/FA adder chain. Produces a 12-bit product, or a 6-bit quotient and remainder, with a start/busy/done handshake. Sits between the I/O wrapper and the adder chain, and is the only block that drives the chain's operand and carry-in controls.

## Interface
- `WIDTH`, default 6: operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  operation request; sampled only in IDLE
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`
- `a`  in  WIDTH  multiplicand or dividend; sampled with `start`
- `b`  in  WIDTH  multiplier or divisor; sampled with `start`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle onward
- `dbz`  out  1  divide-by-zero flag for the last operation
- `result`  out  2*WIDTH  multiply: product; divide: {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, step counter 0..WIDTH-1.
  - DONE: `busy`=1, `done`=1.
- Transitions:
  - IDLE & `start` & !(`op` & `b`==0) → RUN. Latch `op`, `a`, `b`; clear the counter.
  - IDLE & `start` & `op` & `b`==0 → DONE with `dbz`=1. The operation is not iterated. `result` = {a, all-ones}, i.e. quotient 63, remainder `a`.
  - RUN & counter==WIDTH-1 → DONE. Otherwise stay in RUN and increment the counter.
  - DONE → IDLE unconditionally.
- Multiply, per RUN step: 2*WIDTH accumulator {hi, lo}, with lo initialised to `b` and hi to 0.
  - If lo[0] is set, hi += a, and the carry-out is kept as bit WIDTH of the sum.
  - Then shift {carry, hi, lo} right by one.
  - After WIDTH steps, {hi, lo} is the product. Unsigned; there is no overflow.
- Divide, per RUN step: restoring algorithm. Remainder R is WIDTH+1 bits, initialised to 0. Quotient register Q is loaded with `a`.
  - Shift {R, Q} left by one.
  - Trial T = R − {0, b}. If T is non-negative, R = T and Q[0] = 1; else Q[0] = 0.
  - Unsigned operands.
- `result` and `dbz` are registered and updated only on entry to DONE. They hold their value until the next entry to DONE. `dbz` is cleared on a normal completion.
- `start` while `busy` is ignored. No queuing, no error indication.
- Reset:
  - `rst`=1 at any edge gives state IDLE, counter 0, `busy`=0, `done`=0, `dbz`=0, `result`=0, and internal registers 0.
  - Reset mid-operation aborts it, and no `done` follows.
  - `start` in the same cycle as `rst` is ignored.

## Timing
- Cycle 0: `start` is high and is sampled at the edge ending cycle 0.
- Cycles 1..WIDTH: RUN. With WIDTH=6 this is cycles 1–6.
- Cycle WIDTH+1 (7): DONE, with `done`=1 and `result` valid.
- Cycle WIDTH+2: IDLE. The next `start` is accepted at the end of this cycle at the earliest, giving a throughput of one operation per WIDTH+2 cycles.
- Divide by zero: DONE in cycle 1, IDLE in cycle 2.
- `start` held high continuously means back-to-back operations, each re-sampling `op`, `a` and `b` in IDLE.
- `busy` and `done` are registered state decodes, with no combinational path from the inputs.
- Operands may change freely after cycle 0 without affecting the operation in flight.

## Test plan
- Multiply: `op`=0, `a`=63, `b`=63 → `done` in cycle 7, `result`=3969 (0xF81), `dbz`=0. Also `a`=5, `b`=0 → `result`=0.
- Divide: `op`=1, `a`=45, `b`=7 → `done` in cycle 7, `result`={3,6}=198, `dbz`=0. Also `a`=5, `b`=9 → quotient 0, remainder 5, `result`=320.
- Divide by zero: `op`=1, `a`=13, `b`=0 → `done` in cycle 1, `dbz`=1, `result`=895. A following 6×7 clears `dbz` and gives `result`=42.
- Busy rejection: `start` pulsed in cycles 3 and 7 with different operands → only the first operation completes. `result` is unchanged by the ignored starts, with exactly one `done`.
- Reset mid-RUN: `rst` in cycle 4 → `busy`=0 next cycle, no `done`, and `result`=0. A fresh 2×3 then completes with `result`=6.
- Back-to-back with `start` held high: 10×10 then 60/4 → `done` pulses 8 cycles apart, with `result`=100 then `result`={0,15}=15.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide sequencer.
// One bit per clock through a single shared adder: a shift-add multiply
// or a restoring divide. Start/busy/done handshake. Divide by zero
// completes immediately with dbz set.
module muldiv_seq #(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  // Multiply: multiplicand. Divide: divisor.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Multiply: accumulator high half (top bit stays 0). Divide: remainder R.
  logic [WIDTH:0]     hi_q, hi_d;
  // Multiply: accumulator low half. Divide: quotient register Q.
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  // Shared adder chain and per-step datapath
  logic [WIDTH:0]     add_x, add_y;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;

  // Operand/carry-in steering for the adder and the resulting next-step values.
  // Divide subtracts via add of the inverted divisor with carry-in 1; the
  // carry-out is then the "trial is non-negative" flag.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    if (op_q) begin
      add_x   = div_shift;
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = hi_q;
      add_y   = lo_q[0] ? {1'b0, opnd_q} : '0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    div_ok  = add_sum[WIDTH+1];
    if (op_q) begin
      step_hi = div_ok ? add_sum[WIDTH:0] : div_shift;
      step_lo = {lo_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi = {1'b0, add_sum[WIDTH:1]};
      step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sequencer next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b == '0)) begin
            state_d  = S_DONE;
            dbz_d    = 1'b1;
            result_d = {a, {WIDTH{1'b1}}};
          end else begin
            state_d = S_RUN;
            op_d    = op;
            opnd_d  = op ? b : a;
            lo_d    = op ? a : b;
            hi_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          dbz_d    = 1'b0;
          // Both ops pack the same way: {hi, lo} or {R, Q}.
          result_d = {step_hi[WIDTH-1:0], step_lo};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign dbz    = dbz_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq with hand-computed results.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [11:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .dbz    (dbz),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op from an IDLE cycle; wait (bounded) for done and check it.
  task automatic run_op(input string tag, input logic o, input logic [5:0] x,
                        input logic [5:0] y, input logic [11:0] er,
                        input logic ed, input int el);
    int seen;
    seen = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = 6'($urandom);
        b = 6'($urandom);
        op = ~o;
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (done) seen = k;
    end
    check({tag, "_lat"}, 32'(seen), 32'(el));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_dbz"}, 32'(dbz), 32'(ed));
  endtask

  initial begin
    int ndone;
    int k1;
    int k2;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    // start during reset is ignored
    start = 1'b1; op = 1'b0; a = 6'd3; b = 6'd3;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;

    run_op("mul63", 1'b0, 6'd63, 6'd63, 12'd3969, 1'b0, 7);
    run_op("mul5x0", 1'b0, 6'd5, 6'd0, 12'd0, 1'b0, 7);
    run_op("div45_7", 1'b1, 6'd45, 6'd7, 12'd198, 1'b0, 7);
    run_op("div5_9", 1'b1, 6'd5, 6'd9, 12'd320, 1'b0, 7);
    run_op("dbz13", 1'b1, 6'd13, 6'd0, 12'd895, 1'b1, 1);
    run_op("mul6x7", 1'b0, 6'd6, 6'd7, 12'd42, 1'b0, 7);

    // Busy rejection: 9x5, extra starts in cycles 3 and 7
    @(negedge clk);
    ndone = 0;
    op = 1'b0; a = 6'd9; b = 6'd5; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; op = 1'b1; a = 6'd63; b = 6'd2; end
      if (k == 4) start = 1'b0;
      if (done) ndone++;
      if (k == 7) begin
        check("busyrej_res7", 32'(result), 32'd45);
        start = 1'b1; op = 1'b0; a = 6'd1; b = 6'd1;
      end
      if (k == 8) start = 1'b0;
      if (k == 9) check("busyrej_idle", 32'(busy), 32'd0);
    end
    check("busyrej_ndone", 32'(ndone), 32'd1);
    check("busyrej_res", 32'(result), 32'd45);

    // Reset mid-RUN
    @(negedge clk);
    ndone = 0;
    op = 1'b0; a = 6'd3; b = 6'd5; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res", 32'(result), 32'd0);
        rst = 1'b0;
      end
      if (done) ndone++;
    end
    check("midrst_ndone", 32'(ndone), 32'd0);
    run_op("mul2x3", 1'b0, 6'd2, 6'd3, 12'd6, 1'b0, 7);

    // Back-to-back with start held high
    @(negedge clk);
    ndone = 0; k1 = 0; k2 = 0;
    op = 1'b0; a = 6'd10; b = 6'd10; start = 1'b1;
    for (int k = 1; k <= 30 && ndone < 2; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          k1 = k;
          check("b2b_res1", 32'(result), 32'd100);
          op = 1'b1; a = 6'd60; b = 6'd4;
        end else begin
          k2 = k;
          check("b2b_res2", 32'(result), 32'd15);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first", 32'(k1), 32'd7);
    check("b2b_gap", 32'(k2 - k1), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
